// File: rtl/lod_normalizer_pipe_if.sv
// Handshake/data bundle for lod_normalizer_pipe.
//   master : operand producer and result consumer (drives in_valid, num,
//            round_en and out_ready; observes in_ready and the result fields)
//   slave  : the normaliser itself
// Ports carried:
//   in_valid/in_ready   operand handshake
//   num, round_en       operand and per-transaction rounding mode
//   out_valid/out_ready result handshake
//   k, m1, zero, sat    exponent, fraction, zero flag, saturation flag
interface lod_normalizer_pipe_if #(
  parameter int NUM_WIDTH = 32,
  parameter int M1_WIDTH  = 8,
  parameter int K_WIDTH   = $clog2(NUM_WIDTH)
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_WIDTH-1:0] num;
  logic                 round_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [K_WIDTH-1:0]   k;
  logic [M1_WIDTH-1:0]  m1;
  logic                 zero;
  logic                 sat;

  modport master (
    output in_valid, num, round_en, out_ready,
    input  in_ready, out_valid, k, m1, zero, sat
  );

  modport slave (
    input  in_valid, num, round_en, out_ready,
    output in_ready, out_valid, k, m1, zero, sat
  );
endinterface

// File: rtl/lod_normalizer_pipe.sv
// Two-stage leading-one detector / normaliser.
//   Stage 1: registers num, round_en, k = floor(log2(num)) and zero flag.
//   Stage 2: barrel-shifts num so the leading one lands in the MSB, takes the
//            M1_WIDTH bits below it as the fraction, optionally rounds half-up
//            (carrying into k, saturating at k = NUM_WIDTH-1), and registers
//            the result.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (deassertion pre-synchronised)
//   bus    lod_normalizer_pipe_if.slave: in_valid/in_ready, num, round_en,
//          out_valid/out_ready, k, m1, zero, sat
// NUM_WIDTH must be >= 4 and M1_WIDTH in [1, NUM_WIDTH-1].
module lod_normalizer_pipe #(
  parameter  int NUM_WIDTH = 32,
  parameter  int M1_WIDTH  = 8,
  localparam int K_WIDTH   = $clog2(NUM_WIDTH)
) (
  input logic                   clk,
  input logic                   rst_n,
  lod_normalizer_pipe_if.slave  bus
);

  localparam logic [K_WIDTH-1:0] KMAX = K_WIDTH'(NUM_WIDTH-1);

  // vld_pipe_q[1] = stage-1 holds data, vld_pipe_q[2] = out_valid
  logic [2:1]           vld_pipe_q, vld_pipe_d;
  logic [NUM_WIDTH-1:0] num1_q, num1_d;
  logic                 rnd1_q, rnd1_d;
  logic [K_WIDTH-1:0]   k1_q, k1_d;
  logic                 zero1_q, zero1_d;
  logic [K_WIDTH-1:0]   k_q, k_d;
  logic [M1_WIDTH-1:0]  m1_q, m1_d;
  logic                 zero_q, zero_d;
  logic                 sat_q, sat_d;

  // Elastic flow control: each stage moves when its successor is free or
  // draining in the same cycle, so accept and drain together keep 1/cycle.
  logic s2_adv, s1_adv;
  assign s2_adv       = ~vld_pipe_q[2] | bus.out_ready;
  assign s1_adv       = ~vld_pipe_q[1] | s2_adv;
  assign bus.in_ready = s1_adv;

  // ---------------- stage 1: leading-one detect ----------------
  logic [K_WIDTH-1:0] lod_k;
  logic               lod_zero;

  always_comb begin
    lod_k = '0;
    // ascending scan: the last hit is the highest set bit
    for (int i = 0; i < NUM_WIDTH; i++)
      if (bus.num[i]) lod_k = K_WIDTH'(i);
  end
  assign lod_zero = ~|bus.num;

  // ---------------- stage 2: normalise and round ----------------
  logic [K_WIDTH-1:0]              sh;
  logic [K_WIDTH:0][NUM_WIDTH-1:0] bar;
  logic [NUM_WIDTH-1:0]            s;
  logic [M1_WIDTH-1:0]             t;
  logic                            rbit;

  // k <= NUM_WIDTH-1, so the shift distance never goes negative
  assign sh     = KMAX - k1_q;
  assign bar[0] = num1_q;

  // log2-stage barrel: stage g shifts by 2**g when bit g of the distance is set
  for (genvar g = 0; g < K_WIDTH; g++) begin : g_bar
    assign bar[g+1] = sh[g] ? (bar[g] << (2**g)) : bar[g];
  end
  assign s = bar[K_WIDTH];
  assign t = s[NUM_WIDTH-2 -: M1_WIDTH];

  // the round bit exists only if a bit remains below the fraction field
  if (M1_WIDTH <= NUM_WIDTH-2) begin : g_rbit
    assign rbit = s[NUM_WIDTH-2-M1_WIDTH];
  end else begin : g_nor
    assign rbit = 1'b0;
  end

  // the MSB and the bits below the round bit are intentionally dropped
  logic [NUM_WIDTH-1:0] unused_s;
  assign unused_s = s;

  logic [K_WIDTH-1:0]  k_res;
  logic [M1_WIDTH-1:0] m1_res;
  logic                sat_res;

  always_comb begin
    k_res   = k1_q;
    m1_res  = t;
    sat_res = 1'b0;
    if (zero1_q) begin
      k_res  = '0;
      m1_res = '0;
    end else if (rnd1_q && rbit) begin
      if (&t) begin
        // fraction wraps: mantissa becomes 1.0 of the next power of two
        if (k1_q == KMAX) begin
          m1_res  = '1;
          sat_res = 1'b1;
        end else begin
          k_res  = k1_q + K_WIDTH'(1);
          m1_res = '0;
        end
      end else begin
        m1_res = t + M1_WIDTH'(1);
      end
    end
  end

  // ---------------- next-state ----------------
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    num1_d     = num1_q;
    rnd1_d     = rnd1_q;
    k1_d       = k1_q;
    zero1_d    = zero1_q;
    k_d        = k_q;
    m1_d       = m1_q;
    zero_d     = zero_q;
    sat_d      = sat_q;
    if (s1_adv) begin
      vld_pipe_d[1] = bus.in_valid;
      if (bus.in_valid) begin
        num1_d  = bus.num;
        rnd1_d  = bus.round_en;
        k1_d    = lod_k;
        zero1_d = lod_zero;
      end
    end
    if (s2_adv) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      // bubbles leave the result registers untouched
      if (vld_pipe_q[1]) begin
        k_d    = k_res;
        m1_d   = m1_res;
        zero_d = zero1_q;
        sat_d  = sat_res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      num1_q     <= '0;
      rnd1_q     <= 1'b0;
      k1_q       <= '0;
      zero1_q    <= 1'b0;
      k_q        <= '0;
      m1_q       <= '0;
      zero_q     <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      num1_q     <= num1_d;
      rnd1_q     <= rnd1_d;
      k1_q       <= k1_d;
      zero1_q    <= zero1_d;
      k_q        <= k_d;
      m1_q       <= m1_d;
      zero_q     <= zero_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.out_valid = vld_pipe_q[2];
  assign bus.k         = k_q;
  assign bus.m1        = m1_q;
  assign bus.zero      = zero_q;
  assign bus.sat       = sat_q;

endmodule
